// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio-path widths, frame length default and read-FSM encoding
package audio_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAME_LEN  = 256;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// rtl/frame_bank_ram.sv - two-bank frame store, synchronous write, asynchronous read
module frame_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256,
  parameter int ADDR_W     = $clog2(FRAME_LEN) + 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:2*FRAME_LEN-1];

  // No reset: stale contents are never read before being rewritten.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mono_sample_framer.sv
// rtl/mono_sample_framer.sv - packs mono sample strobes into ping-pong frames streamed out with TLAST
module mono_sample_framer #(
  parameter int DATA_WIDTH     = audio_pkg::DATA_WIDTH,
  parameter int FRAME_LEN      = audio_pkg::FRAME_LEN,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk_100MHz,
  input  logic                      rst,
  input  logic                      mono_sample_valid,
  input  logic [DATA_WIDTH-1:0]     mono_sample,
  output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  output logic                      frame_overflow,
  output logic [DROP_CNT_WIDTH-1:0] dropped_samples
);

  import audio_pkg::*;

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [1:0]                bank_full_q, bank_full_d;
  logic                      wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]          rd_idx_q, rd_idx_d;
  rd_state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]     tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic                      wr_en, wr_done, rd_free;
  logic [IDX_W-1:0]          rd_addr_idx;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  // Look one word ahead so the next beat is ready to load on the handshake.
  assign rd_addr_idx = (state_q == IDLE) ? '0 : rd_idx_q + 1'b1;

  frame_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_LEN  (FRAME_LEN)
  ) u_ram (
    .clk_i   (clk_100MHz),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_q, wr_idx_q}),
    .wdata_i (mono_sample),
    .raddr_i ({rd_bank_q, rd_addr_idx}),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_en      = mono_sample_valid && !bank_full_q[wr_bank_q];
    wr_done    = wr_en && (wr_idx_q == LAST_IDX);
    wr_bank_d  = wr_bank_q ^ wr_done;
    wr_idx_d   = wr_en ? wr_idx_q + 1'b1 : wr_idx_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (mono_sample_valid && bank_full_q[wr_bank_q]) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    rd_free   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          tdata_d  = ram_rdata;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          rd_idx_d = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (tvalid_q && M_AXIS_TREADY) begin
          if (rd_idx_q != LAST_IDX) begin
            tdata_d  = ram_rdata;
            rd_idx_d = rd_addr_idx;
            tlast_d  = (rd_addr_idx == LAST_IDX);
          end else begin
            rd_free   = 1'b1;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            rd_bank_d = ~rd_bank_q;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Freed and completed banks are always different, so both updates apply.
    bank_full_d = bank_full_q;
    if (rd_free) bank_full_d[rd_bank_q] = 1'b0;
    if (wr_done) bank_full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      state_q     <= IDLE;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign M_AXIS_TDATA    = tdata_q;
  assign M_AXIS_TVALID   = tvalid_q;
  assign M_AXIS_TLAST    = tlast_q;
  assign frame_overflow  = overflow_q;
  assign dropped_samples = drop_cnt_q;

endmodule

// File: tb/tb_mono_sample_framer.sv
// tb/tb_mono_sample_framer.sv - directed and randomized checks of mono_sample_framer against a frame-queue model
module tb_mono_sample_framer;

  localparam int DW = 32;
  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata, tdata_sat;
  logic          tvalid, tlast, ovf;
  logic          tvalid_sat, tlast_sat, ovf_sat;
  logic [15:0]   drops_o;
  logic [3:0]    drops_sat_o;

  always #5 clk = ~clk;

  mono_sample_framer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .DROP_CNT_WIDTH(16)) u_dut (
    .clk_100MHz        (clk),
    .rst               (rst),
    .mono_sample_valid (s_valid),
    .mono_sample       (s_data),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TLAST      (tlast),
    .M_AXIS_TREADY     (tready),
    .frame_overflow    (ovf),
    .dropped_samples   (drops_o)
  );

  mono_sample_framer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .DROP_CNT_WIDTH(4)) u_dut_sat (
    .clk_100MHz        (clk),
    .rst               (rst),
    .mono_sample_valid (s_valid),
    .mono_sample       (s_data),
    .M_AXIS_TDATA      (tdata_sat),
    .M_AXIS_TVALID     (tvalid_sat),
    .M_AXIS_TLAST      (tlast_sat),
    .M_AXIS_TREADY     (tready),
    .frame_overflow    (ovf_sat),
    .dropped_samples   (drops_sat_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: accepted samples in arrival order, and the number of complete frames not yet drained.
  logic [DW-1:0] exp_q[$];
  int            partial = 0;
  int            pending = 0;
  int            beat = 0;
  int            drops = 0;
  bit            armed = 0;
  bit            just_rst = 0;
  bit            prev_tvalid = 0, prev_tready = 0, prev_tlast = 0, prev_last = 0;
  logic [DW-1:0] prev_tdata = '0;
  int            prev_pending = 0;

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic rs);
    bit hs, last;
    int pend_before;
    @(negedge clk);
    if (armed) begin
      if (just_rst) begin
        check("rst_tdata", tdata, 0);
        check("rst_tlast", tlast, 0);
      end
      if (!prev_tvalid) check("tvalid_start", tvalid, prev_pending > 0);
      else if (!prev_tready) begin
        check("hold_tvalid", tvalid, 1);
        check("hold_tdata", tdata, prev_tdata);
        check("hold_tlast", tlast, prev_tlast);
      end else check("tvalid_next", tvalid, !prev_last);
      if (tvalid) check("tlast", tlast, beat == FL - 1);
      check("dropped", drops_o, drops);
      check("dropped_sat", drops_sat_o, (drops > 15) ? 15 : drops);
      check("overflow", ovf, drops > 0);
    end
    just_rst = 0;
    rst = rs; s_valid = v; s_data = d; tready = r;
    if (rs) begin
      exp_q.delete();
      partial = 0; pending = 0; beat = 0; drops = 0;
      armed = 1; just_rst = 1;
      prev_tvalid = 0; prev_tready = 0; prev_last = 0; prev_pending = 0;
    end else if (armed) begin
      hs = tvalid && r;
      last = hs && (beat == FL - 1);
      pend_before = pending;
      if (hs) begin
        if (exp_q.size() == 0) check("beat_extra", 1, 0);
        else check("tdata", tdata, exp_q.pop_front());
        beat = last ? 0 : beat + 1;
      end
      if (v) begin
        if (pending < 2) begin
          exp_q.push_back(d);
          partial++;
          if (partial == FL) begin
            partial = 0;
            pending++;
          end
        end else drops++;
      end
      if (last) pending--;
      prev_tvalid = tvalid; prev_tready = r; prev_tdata = tdata;
      prev_tlast = tlast; prev_last = last; prev_pending = pend_before;
    end
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) cycle(1'b0, '0, r, 1'b0);
  endtask

  task automatic feed(input logic [DW-1:0] val, input int gap, input logic r);
    cycle(1'b1, val, r, 1'b0);
    idle(gap - 1, r);
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int thr;
    do_reset();
    idle(2, 1'b1);

    for (int i = 1; i <= 8; i++) feed(DW'(i), 5, 1'b1);
    idle(12, 1'b1);

    for (int i = 1; i <= 8; i++) feed(DW'(i), 5, 1'b0);
    idle(2, 1'b1);
    idle(3, 1'b0);
    idle(12, 1'b1);

    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(32'h10 + i), !(i >= 10 && i < 14), 1'b0);
    idle(30, 1'b1);

    do_reset();
    for (int i = 1; i <= 20; i++) feed(DW'(i), 1, 1'b0);
    idle(1, 1'b0);
    check("ovf_count", drops_o, 4);
    check("ovf_flag", ovf, 1);
    idle(40, 1'b1);

    do_reset();
    for (int i = 1; i <= 40; i++) feed(DW'(i), 1, 1'b0);
    idle(1, 1'b0);
    check("sat_count", drops_sat_o, 4'hF);
    check("sat_wide_count", drops_o, 24);
    idle(40, 1'b1);

    do_reset();
    for (int i = 0; i < 8; i++) feed(DW'(32'h51 + i), 1, 1'b1);
    idle(5, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) feed(DW'(32'h61 + i), 5, 1'b1);
    idle(12, 1'b1);

    do_reset();
    for (int ph = 0; ph < 15; ph++) begin
      case ($urandom_range(0, 2))
        0: thr = 10;
        1: thr = 50;
        default: thr = 95;
      endcase
      for (int c = 0; c < 200; c++) begin
        cycle($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 99) < thr,
              $urandom_range(0, 999) == 0);
      end
    end
    idle(60, 1'b1);
    check("drained", exp_q.size() - partial, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
